// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared constants for the binary up/down counter: default
//                width and the direction encoding of the ctrl input.
//  Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    localparam int   CNT_W_DEFAULT = 4;

    // Direction encoding carried on ctrl
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/binary_up_down_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : binary_up_down_counter_if
//  Description : Bundles the direction input and the count / terminal-count
//                outputs of the up/down counter. The master drives ctrl, the
//                slave (the counter) drives q and tc.
//  Revision    : 1.0 - initial release
// ============================================================================
interface binary_up_down_counter_if
    import counter_pkg::*;
#(
    parameter int WIDTH = CNT_W_DEFAULT
);

    logic             ctrl;
    logic [WIDTH-1:0] q;
    logic             tc;

    modport master (
        output ctrl,
        input  q,
        input  tc
    );

    modport slave (
        input  ctrl,
        output q,
        output tc
    );

endinterface : binary_up_down_counter_if
`default_nettype wire

// File: rtl/binary_up_down_counter.sv
`default_nettype none
// ============================================================================
//  Module      : binary_up_down_counter
//  Description : Free-running WIDTH-bit binary counter. ctrl picks the
//                direction on every rising clk edge; both directions wrap
//                silently modulo 2^WIDTH. tc flags the state just before a
//                wrap in the currently selected direction. Reset is
//                asynchronous, active-high, and clears the count to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module binary_up_down_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = CNT_W_DEFAULT
) (
    input  wire                          clk,
    input  wire                          rst,
    binary_up_down_counter_if.slave      bus
);

    logic [WIDTH-1:0] r_count;
    logic             w_all_ones;
    logic             w_all_zero;

    // Count register: cleared asynchronously, otherwise steps by one each edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (bus.ctrl == DIR_UP) begin
            r_count <= r_count + WIDTH'(1);
        end else begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign w_all_ones = &r_count;
    assign w_all_zero = ~|r_count;

    // Terminal count tracks the wrap boundary of the selected direction
    assign bus.tc = (bus.ctrl == DIR_UP) ? w_all_ones : w_all_zero;
    assign bus.q  = r_count;

endmodule : binary_up_down_counter
`default_nettype wire

// File: tb/tb_binary_up_down_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_binary_up_down_counter
//  Description : Directed bench for the up/down counter: reset behaviour,
//                down wrap, up wrap, direction flips, a long full sequence,
//                and a 3-bit instance counting through its wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_binary_up_down_counter;

    logic clk;
    logic rst;
    logic rst3;

    int n_cmp;
    int n_err;

    binary_up_down_counter_if #(.WIDTH(4)) bus4 ();
    binary_up_down_counter_if #(.WIDTH(3)) bus3 ();

    binary_up_down_counter #(.WIDTH(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    binary_up_down_counter #(.WIDTH(3)) u_dut3 (
        .clk (clk),
        .rst (rst3),
        .bus (bus3)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        rst3  = 1'b1;
        bus4.ctrl = 1'b1;
        bus3.ctrl = 1'b1;
        #2;

        // Reset state and tc during reset
        chk("reset_q", 32'(bus4.q), 32'd0);
        chk("reset_tc_up", 32'(bus4.tc), 32'd0);
        bus4.ctrl = 1'b0;
        #1;
        chk("reset_tc_down", 32'(bus4.tc), 32'd1);

        // Down count from 0 with wrap: 15,14,...,1,0,15
        step();
        rst = 1'b0;
        chk("down_start_q", 32'(bus4.q), 32'd0);
        for (int i = 1; i <= 17; i++) begin
            step();
            chk("down_q", 32'(bus4.q), 32'((16 - i) & 15));
            chk("down_tc", 32'(bus4.tc), (((16 - i) & 15) == 0) ? 32'd1 : 32'd0);
        end

        // Bring q to 14, then count up through the wrap: 15,0,1,2
        step();
        chk("pre_up_q", 32'(bus4.q), 32'd14);
        bus4.ctrl = 1'b1;
        #1;
        chk("pre_up_tc", 32'(bus4.tc), 32'd0);
        step(); chk("up_q15", 32'(bus4.q), 32'd15); chk("up_tc15", 32'(bus4.tc), 32'd1);
        step(); chk("up_q0",  32'(bus4.q), 32'd0);  chk("up_tc0",  32'(bus4.tc), 32'd0);
        step(); chk("up_q1",  32'(bus4.q), 32'd1);
        step(); chk("up_q2",  32'(bus4.q), 32'd2);

        // Continue to 6, then flip direction twice
        for (int v = 3; v <= 6; v++) begin
            step();
            chk("climb_q", 32'(bus4.q), 32'(v));
        end
        bus4.ctrl = 1'b0;
        step(); chk("flip_dn5", 32'(bus4.q), 32'd5);
        step(); chk("flip_dn4", 32'(bus4.q), 32'd4);
        bus4.ctrl = 1'b1;
        step(); chk("flip_up5", 32'(bus4.q), 32'd5);
        step(); chk("flip_up6", 32'(bus4.q), 32'd6);

        // Climb to 9, then assert reset mid-cycle
        step(); step(); step();
        chk("mid_q9", 32'(bus4.q), 32'd9);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_q", 32'(bus4.q), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_hold_q", 32'(bus4.q), 32'd0);
        end

        // Full sequence: 17 down edges then 17 up edges
        bus4.ctrl = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 17; i++) step();
        chk("full_down_q", 32'(bus4.q), 32'd15);
        bus4.ctrl = 1'b1;
        for (int i = 0; i < 17; i++) step();
        chk("full_up_q", 32'(bus4.q), 32'd0);

        // 3-bit instance: up from 0 for 9 edges -> 1..7,0,1
        chk("w3_reset_q", 32'(bus3.q), 32'd0);
        rst3 = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("w3_q", 32'(bus3.q), 32'(i & 7));
            chk("w3_tc", 32'(bus3.tc), ((i & 7) == 7) ? 32'd1 : 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_binary_up_down_counter
`default_nettype wire
